avalon_sdram_responder: RTL and testbench
=========================================

Name: avalon_sdram_responder

Overview:
- Avalon-MM slave (responder) that answers the read/write/burst traffic our SDRAM master logic issues toward the SDRAM bridge.
- Backed by an on-chip word array.
- Inserts programmable waitrequest stalls and a fixed read latency, so master-side FSMs can be exercised in simulation and on FPGA without the real SDRAM controller.
- Sits on the bridge side of the avalon_sdr master; its ports are the mirror image of the master's avm_m0 bus.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing array (power of 2).
- WAIT_CYCLES, 2, waitrequest-high cycles before each command is accepted (0 = accept immediately).
- READ_LATENCY, 3, cycles from read acceptance to first readdatavalid (must be >= 1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- avs_s0_read  in  1  read request.
- avs_s0_write  in  1  write request / write beat.
- avs_s0_address  in  32  byte address; word index = address[log2(DEPTH)+1:2], upper bits ignored (wraps modulo DEPTH).
- avs_s0_writedata  in  32  write data.
- avs_s0_byteenable  in  4  per-byte write mask; ignored on reads.
- avs_s0_burstcount  in  11  beats in burst; 0 treated as 1.
- avs_s0_readdata  out  32  read data, registered.
- avs_s0_readdatavalid  out  1  one pulse per read beat.
- avs_s0_waitrequest  out  1  stall; a command is accepted only in a cycle where it is low.
- protocol_err  out  1  sticky violation flag, cleared only by reset.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clock. All state goes to IDLE on reset.
- Reset values: readdata=0, readdatavalid=0, protocol_err=0, waitrequest=1 while reset is high. Array contents are not cleared.
- Waitrequest decode is combinational from state and counter:
  - IDLE: low only if WAIT_CYCLES=0.
  - STALL: high until the counter expires; low in the accept cycle.
  - WRITE_BURST: low.
  - READ_WAIT and READ_DATA: high.
- FSM states: IDLE, STALL, WRITE_BURST, READ_WAIT, READ_DATA.
- IDLE, first command seen at cycle T0:
  - WAIT_CYCLES>0: go to STALL. Waitrequest is high during T0..T0+WAIT_CYCLES-1 and low at T0+WAIT_CYCLES, which is the accept cycle A.
  - WAIT_CYCLES=0: A=T0.
  - Command fields are sampled at A. The master must hold them stable while stalled; a change of address, read or write during STALL sets protocol_err.
- Write accept at A:
  - Beat 0 is written at the clock edge ending A, with byteenable merge (unmasked bytes keep their old value).
  - beats_left = burstcount-1; word pointer = index+1.
  - If beats_left=0, return to IDLE; otherwise go to WRITE_BURST.
- WRITE_BURST:
  - Each cycle with write=1 writes writedata at the pointer, then pointer+1 and beats_left-1.
  - write=0 is an idle cycle; nothing advances.
  - address is ignored.
  - Leave for IDLE after the last beat.
  - read=1 here sets protocol_err and is ignored.
- Read accept at A:
  - Enter READ_WAIT with latency counter = READ_LATENCY-1.
  - First beat: readdatavalid=1 at A+READ_LATENCY, readdata = array[index].
  - Remaining burstcount-1 beats follow on consecutive cycles from incrementing word addresses (READ_DATA).
  - readdatavalid is low on every other cycle.
  - Return to IDLE the cycle after the last beat; the next command can be accepted no earlier than that IDLE cycle (plus stall).
- Simultaneous read and write in IDLE: the write wins and protocol_err is set.
- Address wrap: the pointer wraps from DEPTH-1 to 0 within a burst.
- Reset mid-burst: the FSM aborts to IDLE immediately.
  - Already-written beats remain in the array.
  - readdatavalid drops asynchronously.
- Widths:
  - beats_left is 11 bits; the burstcount maximum is 1024 beats.
  - The latency and stall counters are sized with $clog2 of their parameter +1.

Decomposition:
- sdram_pkg holds:
  - the responder state enum;
  - constants AVM_DATA_W=32, AVM_BE_W=4, AVM_BURST_W=11.
- Sub-module sdram_model_mem:
  - single-port word array;
  - synchronous read with registered output;
  - byte-enabled synchronous write.
- The FSM, counters and the readdatavalid pipeline stay in the top module.

Test Plan:
- Single write, then read, WAIT_CYCLES=2, READ_LATENCY=3: write addr 0x10 data 0xDEADBEEF, byteenable 0xF.
  - Expect waitrequest high 2 cycles, then low 1 cycle.
  - The read at 0x10 returns readdatavalid exactly 3 cycles after acceptance with 0xDEADBEEF.
- Byteenable merge: write 0x11223344 to 0x20, then 0xAABBCCDD with byteenable 0x5 -> read returns 0x11BB33DD.
- Burst write 4 beats from 0x40 with data 1..4, then a 4-beat burst read from 0x40.
  - Insert one write=0 gap mid-burst.
  - Expect 4 consecutive readdatavalid pulses with 1,2,3,4 and waitrequest high throughout the read.
- Wrap-around, DEPTH=1024: 2-beat burst write at address 0xFFC (word 1023) with 7 and 8 -> word 0 reads back 8.
- Protocol errors: assert read and write together in IDLE -> write performed, protocol_err=1 and stays 1 until reset.
- Reset mid-operation: assert reset during beat 2 of a 4-beat read.
  - readdatavalid=0 and waitrequest=1 immediately.
  - After release, a new single read completes normally and array data is intact.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and bus constants for the Avalon SDRAM responder model.
// Bus widths mirror the avm_m0 master port it answers.
package sdram_pkg;

    localparam int AVM_DATA_W  = 32;
    localparam int AVM_BE_W    = 4;
    localparam int AVM_BURST_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_STALL       = 3'd1,
        ST_WRITE_BURST = 3'd2,
        ST_READ_WAIT   = 3'd3,
        ST_READ_DATA   = 3'd4
    } resp_state_e;

    // A burstcount of zero is treated as a single beat.
    function automatic logic [AVM_BURST_W-1:0] burst_minus_one(input logic [AVM_BURST_W-1:0] bc);
        return (bc == '0) ? '0 : bc - AVM_BURST_W'(1);
    endfunction

endpackage

// File: rtl/sdram_model_mem.sv
// Single-port backing word array: byte-enabled synchronous write,
// synchronous read into an output register that resets to zero.
module sdram_model_mem
    import sdram_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       we,
    input  logic [AVM_BE_W-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [AVM_DATA_W-1:0]      wdata,
    output logic [AVM_DATA_W-1:0]      rdata
);

    logic [AVM_DATA_W-1:0] mem_r [DEPTH];
    logic [AVM_DATA_W-1:0] rdata_r;

    // Byte-lane write; the array contents survive reset.
    always_ff @(posedge clock) begin
        if (en && we) begin
            for (int b = 0; b < AVM_BE_W; b++) begin
                if (be[b]) begin
                    mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_r <= '0;
        end else if (en && !we) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/avalon_sdram_responder.sv
// Avalon-MM responder standing in for the SDRAM bridge: programmable
// waitrequest stalls, fixed read latency, bursts, sticky protocol flag.
module avalon_sdram_responder
    import sdram_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    avs_s0_read,
    input  logic                    avs_s0_write,
    input  logic [31:0]             avs_s0_address,
    input  logic [AVM_DATA_W-1:0]   avs_s0_writedata,
    input  logic [AVM_BE_W-1:0]     avs_s0_byteenable,
    input  logic [AVM_BURST_W-1:0]  avs_s0_burstcount,
    output logic [AVM_DATA_W-1:0]   avs_s0_readdata,
    output logic                    avs_s0_readdatavalid,
    output logic                    avs_s0_waitrequest,
    output logic                    protocol_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int STALL_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int LAT_W   = $clog2(READ_LATENCY + 1);
    localparam logic [STALL_W-1:0] STALL_INIT = STALL_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [LAT_W-1:0]   LAT_INIT   = LAT_W'(READ_LATENCY - 1);
    localparam bit NO_STALL = (WAIT_CYCLES == 0);
    localparam bit LAT_ONE  = (READ_LATENCY == 1);

    resp_state_e              state_r;
    logic [STALL_W-1:0]       stall_cnt_r;
    logic [LAT_W-1:0]         lat_cnt_r;
    logic [AVM_BURST_W-1:0]   beats_left_r;
    logic [AW-1:0]            ptr_r;
    logic [31:0]              cap_addr_r;
    logic                     cap_rd_r;
    logic                     cap_wr_r;
    logic                     rdv_r;
    logic                     err_r;

    logic                     cmd_s;
    logic                     accept_s;
    logic                     wait_s;
    logic [AW-1:0]            index_s;
    logic [AVM_BURST_W-1:0]   bc_m1_s;
    logic                     mem_en_s;
    logic                     mem_we_s;
    logic [AW-1:0]            mem_addr_s;
    logic [AVM_DATA_W-1:0]    mem_rdata_s;

    assign cmd_s    = avs_s0_read | avs_s0_write;
    assign index_s  = avs_s0_address[AW+1:2];
    assign bc_m1_s  = burst_minus_one(avs_s0_burstcount);
    assign accept_s = ((state_r == ST_IDLE) && NO_STALL && cmd_s) ||
                      ((state_r == ST_STALL) && (stall_cnt_r == '0));

    // Waitrequest decode from state and stall counter.
    always_comb begin
        wait_s = 1'b1;
        case (state_r)
            ST_IDLE:                    wait_s = !NO_STALL;
            ST_STALL:                   wait_s = (stall_cnt_r != '0);
            ST_WRITE_BURST:             wait_s = 1'b0;
            ST_READ_WAIT, ST_READ_DATA: wait_s = 1'b1;
            default:                    wait_s = 1'b1;
        endcase
    end

    assign avs_s0_waitrequest = wait_s | reset;

    // Memory port steering: a read is issued one cycle before its beat is presented.
    always_comb begin
        mem_en_s   = 1'b0;
        mem_we_s   = 1'b0;
        mem_addr_s = ptr_r;
        if (accept_s) begin
            mem_addr_s = index_s;
            if (avs_s0_write) begin
                mem_en_s = 1'b1;
                mem_we_s = 1'b1;
            end else if (avs_s0_read && LAT_ONE) begin
                mem_en_s = 1'b1;
            end else begin
                mem_en_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_WRITE_BURST: begin
                    mem_en_s = avs_s0_write;
                    mem_we_s = avs_s0_write;
                end
                ST_READ_WAIT: mem_en_s = (lat_cnt_r == LAT_W'(1));
                ST_READ_DATA: mem_en_s = (beats_left_r != '0);
                default:      mem_en_s = 1'b0;
            endcase
        end
    end

    // Responder FSM, counters, readdatavalid and the sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            stall_cnt_r  <= '0;
            lat_cnt_r    <= '0;
            beats_left_r <= '0;
            ptr_r        <= '0;
            cap_addr_r   <= '0;
            cap_rd_r     <= 1'b0;
            cap_wr_r     <= 1'b0;
            rdv_r        <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            rdv_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_s) begin
                        cap_addr_r  <= avs_s0_address;
                        cap_rd_r    <= avs_s0_read;
                        cap_wr_r    <= avs_s0_write;
                        stall_cnt_r <= STALL_INIT;
                        state_r     <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if ((avs_s0_address != cap_addr_r) || (avs_s0_read != cap_rd_r) ||
                        (avs_s0_write != cap_wr_r)) begin
                        err_r <= 1'b1;
                    end
                    if (stall_cnt_r != '0) begin
                        stall_cnt_r <= stall_cnt_r - STALL_W'(1);
                    end
                end
                ST_WRITE_BURST: begin
                    if (avs_s0_read) begin
                        err_r <= 1'b1;
                    end
                    if (avs_s0_write) begin
                        ptr_r        <= ptr_r + AW'(1);
                        beats_left_r <= beats_left_r - AVM_BURST_W'(1);
                        if (beats_left_r == AVM_BURST_W'(1)) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (lat_cnt_r == LAT_W'(1)) begin
                        state_r <= ST_READ_DATA;
                        rdv_r   <= 1'b1;
                        ptr_r   <= ptr_r + AW'(1);
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                ST_READ_DATA: begin
                    if (beats_left_r == '0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        beats_left_r <= beats_left_r - AVM_BURST_W'(1);
                        ptr_r        <= ptr_r + AW'(1);
                        rdv_r        <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            // Acceptance overrides the per-state updates above; write beats a concurrent read.
            if (accept_s) begin
                beats_left_r <= bc_m1_s;
                if (avs_s0_write) begin
                    if (avs_s0_read) begin
                        err_r <= 1'b1;
                    end
                    ptr_r   <= index_s + AW'(1);
                    state_r <= (bc_m1_s == '0) ? ST_IDLE : ST_WRITE_BURST;
                end else if (avs_s0_read) begin
                    lat_cnt_r <= LAT_INIT;
                    if (LAT_ONE) begin
                        ptr_r   <= index_s + AW'(1);
                        rdv_r   <= 1'b1;
                        state_r <= ST_READ_DATA;
                    end else begin
                        ptr_r   <= index_s;
                        state_r <= ST_READ_WAIT;
                    end
                end else begin
                    state_r <= ST_IDLE;
                end
            end
        end
    end

    sdram_model_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .be    (avs_s0_byteenable),
        .addr  (mem_addr_s),
        .wdata (avs_s0_writedata),
        .rdata (mem_rdata_s)
    );

    assign avs_s0_readdata      = mem_rdata_s;
    assign avs_s0_readdatavalid = rdv_r;
    assign protocol_err         = err_r;

endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Directed bench for avalon_sdram_responder: drivers push expected read beats
// (data and due cycle) into a queue that a negedge monitor pops and checks.
module tb_avalon_sdram_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;
    localparam int LAT   = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        avs_s0_read = 1'b0;
    logic        avs_s0_write = 1'b0;
    logic [31:0] avs_s0_address = 32'd0;
    logic [31:0] avs_s0_writedata = 32'd0;
    logic [3:0]  avs_s0_byteenable = 4'h0;
    logic [10:0] avs_s0_burstcount = 11'd0;
    logic [31:0] avs_s0_readdata;
    logic        avs_s0_readdatavalid;
    logic        avs_s0_waitrequest;
    logic        protocol_err;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wdat [4];
    logic [31:0] rdat [4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    avalon_sdram_responder #(
        .DEPTH        (DEPTH),
        .WAIT_CYCLES  (WAITC),
        .READ_LATENCY (LAT)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .avs_s0_read          (avs_s0_read),
        .avs_s0_write         (avs_s0_write),
        .avs_s0_address       (avs_s0_address),
        .avs_s0_writedata     (avs_s0_writedata),
        .avs_s0_byteenable    (avs_s0_byteenable),
        .avs_s0_burstcount    (avs_s0_burstcount),
        .avs_s0_readdata      (avs_s0_readdata),
        .avs_s0_readdatavalid (avs_s0_readdatavalid),
        .avs_s0_waitrequest   (avs_s0_waitrequest),
        .protocol_err         (protocol_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every readdatavalid beat must match the head of the queue in data and cycle.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (avs_s0_readdatavalid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat cyc=%0d got=%h expected no beat", cyc, avs_s0_readdata);
                end else begin
                    e = exp_q.pop_front();
                    if (avs_s0_readdata !== e.data || cyc != e.due || avs_s0_waitrequest !== 1'b1) begin
                        errors++;
                        $display("FAIL read_beat got data=%h cyc=%0d wait=%b want data=%h cyc=%0d wait=1",
                                 avs_s0_readdata, cyc, avs_s0_waitrequest, e.data, e.due);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missing_beat cyc=%0d got no readdatavalid want data=%h at cyc=%0d", cyc, e.data, e.due);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Present a command at a negedge and hold it until waitrequest drops; acc = accept cycle.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [10:0] bc, output int acc);
        int n;
        n = 0;
        @(negedge clock);
        avs_s0_read       = rd;
        avs_s0_write      = wr;
        avs_s0_address    = addr;
        avs_s0_writedata  = data;
        avs_s0_byteenable = be;
        avs_s0_burstcount = bc;
        while (avs_s0_waitrequest === 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        acc = cyc;
        chk("stall_cycles", 32'(n), 32'(WAITC));
    endtask

    task automatic write_burst(input logic [31:0] addr, input int n, input logic [3:0] be, input int gap);
        int acc;
        issue(1'b0, 1'b1, addr, wdat[0], be, 11'(n), acc);
        for (int i = 1; i < n; i++) begin
            @(negedge clock);
            if (i == gap) begin
                avs_s0_write = 1'b0;
                @(negedge clock);
                avs_s0_write = 1'b1;
            end
            avs_s0_writedata = wdat[i];
            chk("burst_waitreq", 32'(avs_s0_waitrequest), 32'd0);
        end
        @(negedge clock);
        avs_s0_write = 1'b0;
        avs_s0_read  = 1'b0;
    endtask

    task automatic read_burst(input logic [31:0] addr, input int n);
        int   acc;
        int   t;
        exp_t e;
        issue(1'b1, 1'b0, addr, 32'd0, 4'hF, 11'(n), acc);
        for (int k = 0; k < n; k++) begin
            e.data = rdat[k];
            e.due  = acc + LAT + k;
            exp_q.push_back(e);
        end
        @(negedge clock);
        avs_s0_read = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clock);
            #1;
            t++;
        end
        chk("read_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int t;
        exp_t e;
        repeat (3) @(negedge clock);
        chk("rst_readdata", avs_s0_readdata, 32'd0);
        chk("rst_rdvalid", 32'(avs_s0_readdatavalid), 32'd0);
        chk("rst_waitreq", 32'(avs_s0_waitrequest), 32'd1);
        chk("rst_proterr", 32'(protocol_err), 32'd0);
        reset = 1'b0;

        wdat[0] = 32'hDEADBEEF;
        write_burst(32'h10, 1, 4'hF, -1);
        rdat[0] = 32'hDEADBEEF;
        read_burst(32'h10, 1);

        wdat[0] = 32'h11223344;
        write_burst(32'h20, 1, 4'hF, -1);
        wdat[0] = 32'hAABBCCDD;
        write_burst(32'h20, 1, 4'h5, -1);
        rdat[0] = 32'h11BB33DD;
        read_burst(32'h20, 1);

        wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'd4;
        write_burst(32'h40, 4, 4'hF, 2);
        rdat[0] = 32'd1; rdat[1] = 32'd2; rdat[2] = 32'd3; rdat[3] = 32'd4;
        read_burst(32'h40, 4);

        wdat[0] = 32'd7; wdat[1] = 32'd8;
        write_burst(32'hFFC, 2, 4'hF, -1);
        rdat[0] = 32'd8;
        read_burst(32'h0, 1);
        rdat[0] = 32'd7; rdat[1] = 32'd8;
        read_burst(32'hFFC, 2);
        chk("proterr_clean", 32'(protocol_err), 32'd0);

        issue(1'b1, 1'b1, 32'h80, 32'h5A5A5A5A, 4'hF, 11'd1, acc);
        @(negedge clock);
        avs_s0_read  = 1'b0;
        avs_s0_write = 1'b0;
        @(negedge clock);
        chk("proterr_set", 32'(protocol_err), 32'd1);
        rdat[0] = 32'h5A5A5A5A;
        read_burst(32'h80, 1);
        chk("proterr_sticky", 32'(protocol_err), 32'd1);

        // Reset lands on the cycle presenting the second of four beats.
        issue(1'b1, 1'b0, 32'h40, 32'd0, 4'hF, 11'd4, acc);
        for (int k = 0; k < 2; k++) begin
            e.data = 32'(k + 1);
            e.due  = acc + LAT + k;
            exp_q.push_back(e);
        end
        @(negedge clock);
        avs_s0_read = 1'b0;
        t = 0;
        while (cyc < acc + LAT + 1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_rdvalid", 32'(avs_s0_readdatavalid), 32'd0);
        chk("midrst_waitreq", 32'(avs_s0_waitrequest), 32'd1);
        chk("midrst_readdata", avs_s0_readdata, 32'd0);
        chk("midrst_proterr", 32'(protocol_err), 32'd0);
        chk("midrst_beats_seen", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        rdat[0] = 32'hDEADBEEF;
        read_burst(32'h10, 1);
        rdat[0] = 32'd1; rdat[1] = 32'd2; rdat[2] = 32'd3; rdat[3] = 32'd4;
        read_burst(32'h40, 4);

        repeat (4) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
